// File: rtl/circuit_pkg.sv
// Shared definitions for the sample-processing circuit and its feeder.
package circuit_pkg;

  localparam int unsigned CIRCUIT_DATA_W = 32;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } feeder_state_t;

endpackage

// File: rtl/circuit_feeder_fifo.sv
// Synchronous FIFO with registered level/full/empty; head is the oldest entry.
module circuit_feeder_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      // Flags are derived from the pre-edge level so they stay registered.
      case ({push, pop})
        2'b10: begin
          level <= level + LW'(1);
          full  <= (level == LW'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          level <= level - LW'(1);
          full  <= 1'b0;
          empty <= (level == LW'(1));
        end
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/circuit_feeder.sv
// Buffers stream words and issues them as spaced single-cycle en strobes with x.
module circuit_feeder
  import circuit_pkg::*;
#(
  parameter int unsigned DATA_W = CIRCUIT_DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned GAP    = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   en,
  output logic [DATA_W-1:0]      x,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       issued,
  output logic                   busy
);

  localparam int unsigned GW = $clog2(GAP + 1);

  feeder_state_t     state;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              issue;

  assign s_ready = !full;
  assign push    = s_valid && s_ready;
  assign issue   = (state == ST_IDLE) && run && !empty;
  assign busy    = !empty || (state != ST_IDLE);

  circuit_feeder_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (issue),
    .din   (s_data),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      en      <= 1'b0;
      x       <= '0;
      issued  <= '0;
    end else begin
      en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            en     <= 1'b1;
            x      <= head;
            issued <= issued + CNT_W'(1);
            if (GAP > 1) begin
              state   <= ST_WAIT;
              gap_cnt <= GW'(GAP - 1);
            end
          end
        end
        ST_WAIT: begin
          // Leaving at count 1 puts the next issue exactly GAP edges after the last.
          if (gap_cnt <= GW'(1)) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit_feeder.sv
// Randomised and directed bench for circuit_feeder against a cycle-count reference model.
module tb_circuit_feeder;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned GAP    = 2;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              en;
  logic [DATA_W-1:0] x;
  logic [2:0]        level;
  logic [CNT_W-1:0]  issued;
  logic              busy;

  circuit_feeder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .GAP    (GAP),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .en      (en),
    .x       (x),
    .level   (level),
    .issued  (issued),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: accepted words in a queue, strobes spaced by edge count.
  logic [DATA_W-1:0] q[$];
  int                edge_no   = 0;
  int                last_edge = -1000;
  logic [CNT_W-1:0]  m_issued  = '0;
  logic [DATA_W-1:0] m_x       = '0;
  logic              m_en      = 1'b0;
  bit                m_pushed  = 1'b0;
  int                n_checks  = 0;
  int                n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, edge_no, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return (q.size() > 0) || ((edge_no - last_edge) < int'(GAP) - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    edge_no++;
    m_pushed = 1'b0;
    m_en     = 1'b0;
    if (rst) begin
      q.delete();
      m_issued  = '0;
      m_x       = '0;
      last_edge = -1000;
    end else begin
      m_pushed = s_valid && (q.size() < DEPTH);
      if (run && q.size() > 0 && (edge_no - last_edge) >= int'(GAP)) begin
        m_x = q.pop_front();
        m_en = 1'b1;
        m_issued++;
        last_edge = edge_no;
      end
      if (m_pushed) q.push_back(s_data);
    end
    #1;
    check("en",      32'(en),      32'(m_en));
    check("x",       x,            m_x);
    check("level",   32'(level),   32'(q.size()));
    check("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
    check("issued",  32'(issued),  32'(m_issued));
    check("busy",    32'(busy),    32'(m_busy()));
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && m_busy(); i++) step();
    check("drained", 32'(m_busy()), 32'(0));
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    int                seen;

    // Reset then idle
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Single word: strobe one edge after acceptance
    run = 1'b1; s_valid = 1'b1; s_data = 32'h5;
    step();
    s_valid = 1'b0;
    step();
    check("single_en", 32'(en), 32'(1));
    check("single_x",  x,       32'h5);
    drain();

    // Cadence: continuous push of 0..99
    v = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 400 && v < 100; i++) begin
      s_data = v;
      step();
      if (m_pushed) v++;
    end
    s_valid = 1'b0;
    drain();
    check("cadence_issued", 32'(issued), 32'd101);

    // Back-pressure: six offers with run low, only four fit
    run = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 32'h100 + i;
      step();
    end
    s_valid = 1'b0;
    check("full_level", 32'(level),   32'd4);
    check("full_ready", 32'(s_ready), 32'd0);
    run = 1'b1;
    drain();
    check("full_last_x", x, 32'h103);

    // Run gating: drop run in the cycle right after a strobe
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 32'h200 + i;
      step();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 10 && !en; i++) step();
    run = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("gated_en", 32'(en), 32'd0);
    run = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !en; i++) step();
    check("resume_en", 32'(en), 32'd1);
    drain();

    // Reset mid-operation with three queued words and FSM waiting
    s_valid = 1'b1;
    for (int i = 0; i < 12 && !(q.size() == 3 && m_busy() && (edge_no - last_edge) < int'(GAP) - 1); i++) begin
      s_data = 32'h300 + edge_no;
      step();
    end
    s_valid = 1'b0;
    check("pre_reset_level", 32'(level), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_level",  32'(level),  32'd0);
    check("rst_issued", 32'(issued), 32'd0);
    s_valid = 1'b1; s_data = 32'hA5;
    step();
    s_valid = 1'b0;
    step();
    check("after_rst_x", x, 32'hA5);
    drain();

    // Random traffic with occasional run drops and resets
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      run     = ($urandom_range(0, 4) != 0);
      rst     = ($urandom_range(0, 99) == 0);
      step();
      if (en) seen++;
    end
    rst = 1'b0; s_valid = 1'b0; run = 1'b1;
    drain();
    check("random_activity", 32'(seen > 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
